// File: rtl/dmem_responder_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : dmem_responder_pkg
//  Description : Shared definitions for the dCPU memory responder: bus
//                widths, default MMIO address and FSM state encoding.
//  Revision    : 1.0 - initial release
// ============================================================================
package dmem_responder_pkg;

  localparam int DMEM_AW = 8;
  localparam int DMEM_DW = 8;

  localparam logic [DMEM_AW-1:0] DMEM_MMIO_DEFAULT = 8'hFE;

  typedef enum logic [1:0] {
    DMEM_LOAD = 2'b00,
    DMEM_HOLD = 2'b01,
    DMEM_RUN  = 2'b10
  } dmem_state_t;

endpackage : dmem_responder_pkg
`default_nettype wire

// File: rtl/dmem_ram.sv
`default_nettype none
// ============================================================================
//  Module      : dmem_ram
//  Description : 256x8 storage, one synchronous write port and one
//                asynchronous read port. Contents are never reset.
//  Revision    : 1.0 - initial release
// ============================================================================
module dmem_ram
  import dmem_responder_pkg::*;
(
  input  logic               clk,
  input  logic               we,
  input  logic [DMEM_AW-1:0] waddr,
  input  logic [DMEM_DW-1:0] wdata,
  input  logic [DMEM_AW-1:0] raddr,
  output logic [DMEM_DW-1:0] rdata
);

  logic [DMEM_DW-1:0] r_mem [0:(1<<DMEM_AW)-1];

  // Synchronous write; a same-cycle read still sees the old byte
  always_ff @(posedge clk) begin
    if (we) begin
      r_mem[waddr] <= wdata;
    end
  end

  assign rdata = r_mem[raddr];

endmodule : dmem_ram
`default_nettype wire

// File: rtl/dmem_responder.sv
`default_nettype none
// ============================================================================
//  Module      : dmem_responder
//  Description : dCPU bus memory responder. Boots a program image from a
//                byte stream while holding the CPU in reset, then serves
//                CPU reads/writes with one memory-mapped output port.
//  Revision    : 1.0 - initial release
// ============================================================================
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter logic [DMEM_AW-1:0] MMIO_OUT_ADDR = DMEM_MMIO_DEFAULT,
  parameter int                 HOLD_CYCLES   = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               R,
  input  logic               W,
  input  logic [DMEM_AW-1:0] addr,
  input  logic [DMEM_DW-1:0] data_in,
  output logic [DMEM_DW-1:0] mem_out,
  input  logic               ld_valid,
  input  logic [DMEM_DW-1:0] ld_data,
  input  logic               ld_last,
  input  logic               skip_load,
  output logic               ld_ready,
  output logic               cpu_rst,
  output logic               out_valid,
  output logic [DMEM_DW-1:0] out_data,
  output logic               bus_err
);

  // Hold counter runs 0..HOLD_CYCLES-1; the terminal value triggers RUN
  localparam logic [3:0] c_HOLD_LAST = 4'(HOLD_CYCLES - 1);
  localparam logic [DMEM_AW-1:0] c_PTR_LAST = '1;

  dmem_state_t        r_state;
  dmem_state_t        w_state_nxt;
  logic [DMEM_AW-1:0] r_ptr;
  logic [DMEM_AW-1:0] w_ptr_nxt;
  logic [3:0]         r_hold_cnt;
  logic [3:0]         w_hold_nxt;
  logic               r_out_valid;
  logic [DMEM_DW-1:0] r_out_data;
  logic               r_bus_err;

  logic               w_we;
  logic [DMEM_AW-1:0] w_waddr;
  logic [DMEM_DW-1:0] w_wdata;
  logic               w_mmio_wr;
  logic               w_conflict;
  logic [DMEM_DW-1:0] w_rdata;

  dmem_ram u_ram (
    .clk   (clk),
    .we    (w_we),
    .waddr (w_waddr),
    .wdata (w_wdata),
    .raddr (addr),
    .rdata (w_rdata)
  );

  // Next-state logic and RAM write-port mux (loader in LOAD, CPU in RUN)
  always_comb begin
    w_state_nxt = r_state;
    w_ptr_nxt   = r_ptr;
    w_hold_nxt  = r_hold_cnt;
    w_we        = 1'b0;
    w_waddr     = addr;
    w_wdata     = data_in;
    w_mmio_wr   = 1'b0;
    w_conflict  = 1'b0;
    case (r_state)
      DMEM_LOAD: begin
        // A valid byte wins over skip_load in the same cycle
        if (ld_valid) begin
          w_we      = 1'b1;
          w_waddr   = r_ptr;
          w_wdata   = ld_data;
          w_ptr_nxt = r_ptr + 1'b1;
          if (ld_last || (r_ptr == c_PTR_LAST)) begin
            w_state_nxt = DMEM_HOLD;
          end
        end else if (skip_load) begin
          w_state_nxt = DMEM_HOLD;
        end
      end
      DMEM_HOLD: begin
        if (r_hold_cnt == c_HOLD_LAST) begin
          w_hold_nxt  = 4'd0;
          w_state_nxt = DMEM_RUN;
        end else begin
          w_hold_nxt = r_hold_cnt + 4'd1;
        end
      end
      DMEM_RUN: begin
        // Simultaneous R and W is a bus fault: the read proceeds, the write does not
        w_conflict = ~R & ~W;
        w_we       = ~W & R;
        w_mmio_wr  = w_we && (addr == MMIO_OUT_ADDR);
      end
      default: begin
        w_state_nxt = DMEM_LOAD;
      end
    endcase
  end

  // State, loader pointer, hold counter, MMIO port and sticky error flag
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= DMEM_LOAD;
      r_ptr       <= '0;
      r_hold_cnt  <= 4'd0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_bus_err   <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_ptr       <= w_ptr_nxt;
      r_hold_cnt  <= w_hold_nxt;
      r_out_valid <= w_mmio_wr;
      if (w_mmio_wr) begin
        r_out_data <= data_in;
      end
      if (w_conflict) begin
        r_bus_err <= 1'b1;
      end
    end
  end

  assign ld_ready  = (r_state == DMEM_LOAD);
  assign cpu_rst   = (r_state != DMEM_RUN);
  assign mem_out   = ((r_state == DMEM_RUN) && !R) ? w_rdata : '0;
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign bus_err   = r_bus_err;

endmodule : dmem_responder
`default_nettype wire

// File: tb/tb_dmem_responder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dmem_responder
//  Description : Self-checking bench for dmem_responder: directed boot,
//                read/write, MMIO, conflict and reset scenarios plus a
//                randomized RUN phase against an array-based memory model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_dmem_responder;

  localparam logic [7:0] MMIO = 8'hFE;
  localparam int         HOLD = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic       R, W;
  logic [7:0] addr, data_in, mem_out;
  logic       ld_valid, ld_last, skip_load;
  logic [7:0] ld_data;
  logic       ld_ready, cpu_rst, out_valid, bus_err;
  logic [7:0] out_data;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model of RAM contents and MMIO/error state
  logic [7:0] model_ram [256];
  logic [7:0] exp_out_data;
  logic       exp_out_valid;
  logic       exp_bus_err;

  dmem_responder #(.MMIO_OUT_ADDR(MMIO), .HOLD_CYCLES(HOLD)) dut (
    .clk(clk), .rst(rst), .R(R), .W(W), .addr(addr), .data_in(data_in),
    .mem_out(mem_out), .ld_valid(ld_valid), .ld_data(ld_data),
    .ld_last(ld_last), .skip_load(skip_load), .ld_ready(ld_ready),
    .cpu_rst(cpu_rst), .out_valid(out_valid), .out_data(out_data),
    .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    R = 1'b1; W = 1'b1; addr = 8'h00; data_in = 8'h00;
    ld_valid = 1'b0; ld_data = 8'h00; ld_last = 1'b0; skip_load = 1'b0;
  endtask

  task automatic apply_reset();
    idle_inputs();
    rst = 1'b0;
    tick();
    rst = 1'b1;
  endtask

  task automatic test_reset();
    idle_inputs();
    R = 1'b0;
    rst = 1'b0;
    #2;
    n_checks++; if (ld_ready !== 1'b1) $display("FAIL reset_ld_ready: got %b want 1", ld_ready); else n_pass++;
    n_checks++; if (cpu_rst !== 1'b1) $display("FAIL reset_cpu_rst: got %b want 1", cpu_rst); else n_pass++;
    tick();
    n_checks++; if (mem_out !== 8'h00) $display("FAIL reset_mem_out: got %h want 00", mem_out); else n_pass++;
    n_checks++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b want 0", out_valid); else n_pass++;
    n_checks++; if (out_data !== 8'h00) $display("FAIL reset_out_data: got %h want 00", out_data); else n_pass++;
    n_checks++; if (bus_err !== 1'b0) $display("FAIL reset_bus_err: got %b want 0", bus_err); else n_pass++;
    rst = 1'b1;
    R = 1'b1;
  endtask

  // Three-byte boot; CPU strobes (including a conflict) are driven throughout
  // LOAD/HOLD and must have no effect
  task automatic test_load_short();
    logic [7:0] img [3];
    img[0] = 8'h05; img[1] = 8'h63; img[2] = 8'h02;
    for (int i = 0; i < 3; i++) begin
      ld_valid = 1'b1; ld_data = img[i]; ld_last = (i == 2);
      if (i == 1) begin R = 1'b0; W = 1'b0; addr = 8'h00; data_in = 8'h99; end
      tick();
    end
    ld_valid = 1'b0; ld_last = 1'b0;
    for (int k = 0; k < HOLD; k++) begin
      n_checks++; if (cpu_rst !== 1'b1) $display("FAIL hold_cpu_rst_%0d: got %b want 1", k, cpu_rst); else n_pass++;
      n_checks++; if (ld_ready !== 1'b0) $display("FAIL hold_ld_ready_%0d: got %b want 0", k, ld_ready); else n_pass++;
      n_checks++; if (mem_out !== 8'h00) $display("FAIL hold_mem_out_%0d: got %h want 00", k, mem_out); else n_pass++;
      tick();
    end
    R = 1'b1; W = 1'b1;
    n_checks++; if (cpu_rst !== 1'b0) $display("FAIL run_cpu_rst: got %b want 0", cpu_rst); else n_pass++;
    n_checks++; if (ld_ready !== 1'b0) $display("FAIL run_ld_ready: got %b want 0", ld_ready); else n_pass++;
    n_checks++; if (bus_err !== 1'b0) $display("FAIL boot_bus_err: got %b want 0", bus_err); else n_pass++;
    for (int i = 0; i < 3; i++) begin
      model_ram[i] = img[i];
      R = 1'b0; addr = 8'(i);
      #1;
      n_checks++; if (mem_out !== img[i]) $display("FAIL boot_rd_%0d: got %h want %h", i, mem_out, img[i]); else n_pass++;
    end
    R = 1'b1;
  endtask

  task automatic test_run_rw();
    W = 1'b0; addr = 8'h10; data_in = 8'hAB;
    tick();
    W = 1'b1; R = 1'b0;
    #1;
    n_checks++; if (mem_out !== 8'hAB) $display("FAIL rw_read: got %h want ab", mem_out); else n_pass++;
    n_checks++; if (out_valid !== 1'b0) $display("FAIL rw_no_strobe: got %b want 0", out_valid); else n_pass++;
    R = 1'b1;
    #1;
    n_checks++; if (mem_out !== 8'h00) $display("FAIL rw_idle: got %h want 00", mem_out); else n_pass++;
    model_ram[8'h10] = 8'hAB;
  endtask

  task automatic test_mmio();
    W = 1'b0; addr = MMIO; data_in = 8'h68;
    tick();
    W = 1'b1;
    n_checks++; if (out_valid !== 1'b1) $display("FAIL mmio_valid: got %b want 1", out_valid); else n_pass++;
    n_checks++; if (out_data !== 8'h68) $display("FAIL mmio_data: got %h want 68", out_data); else n_pass++;
    tick();
    n_checks++; if (out_valid !== 1'b0) $display("FAIL mmio_one_pulse: got %b want 0", out_valid); else n_pass++;
    R = 1'b0;
    #1;
    n_checks++; if (mem_out !== 8'h68) $display("FAIL mmio_ram: got %h want 68", mem_out); else n_pass++;
    R = 1'b1;
    // back-to-back MMIO writes keep the strobe high
    W = 1'b0; data_in = 8'h11;
    tick();
    n_checks++; if (out_valid !== 1'b1 || out_data !== 8'h11) $display("FAIL b2b_first: got %b/%h want 1/11", out_valid, out_data); else n_pass++;
    data_in = 8'h22;
    tick();
    n_checks++; if (out_valid !== 1'b1 || out_data !== 8'h22) $display("FAIL b2b_second: got %b/%h want 1/22", out_valid, out_data); else n_pass++;
    W = 1'b1;
    tick();
    n_checks++; if (out_valid !== 1'b0) $display("FAIL b2b_end: got %b want 0", out_valid); else n_pass++;
    model_ram[MMIO] = 8'h22;
  endtask

  task automatic test_conflict();
    W = 1'b0; addr = 8'h20; data_in = 8'h11;
    tick();
    R = 1'b0; W = 1'b0; data_in = 8'h55;
    #1;
    n_checks++; if (mem_out !== 8'h11) $display("FAIL conflict_read: got %h want 11", mem_out); else n_pass++;
    tick();
    W = 1'b1;
    n_checks++; if (bus_err !== 1'b1) $display("FAIL conflict_err: got %b want 1", bus_err); else n_pass++;
    #1;
    n_checks++; if (mem_out !== 8'h11) $display("FAIL conflict_nowrite: got %h want 11", mem_out); else n_pass++;
    // conflict on the MMIO address must not touch the output port
    W = 1'b0; addr = MMIO; data_in = 8'h33;
    tick();
    W = 1'b1;
    n_checks++; if (out_valid !== 1'b0 || out_data !== 8'h22) $display("FAIL conflict_mmio: got %b/%h want 0/22", out_valid, out_data); else n_pass++;
    #1;
    n_checks++; if (mem_out !== 8'h22) $display("FAIL conflict_mmio_ram: got %h want 22", mem_out); else n_pass++;
    R = 1'b1;
    tick(); tick();
    n_checks++; if (bus_err !== 1'b1) $display("FAIL conflict_sticky: got %b want 1", bus_err); else n_pass++;
    model_ram[8'h20] = 8'h11;
  endtask

  // 256-byte image without ld_last; loader keeps pushing during HOLD
  task automatic test_full_load();
    apply_reset();
    n_checks++; if (bus_err !== 1'b0) $display("FAIL full_err_cleared: got %b want 0", bus_err); else n_pass++;
    for (int i = 0; i < 256; i++) begin
      ld_valid = 1'b1; ld_data = 8'(i); ld_last = 1'b0;
      tick();
      model_ram[i] = 8'(i);
    end
    ld_data = 8'hEE;
    n_checks++; if (ld_ready !== 1'b0 || cpu_rst !== 1'b1) $display("FAIL full_hold: got ready=%b cpu_rst=%b want 0/1", ld_ready, cpu_rst); else n_pass++;
    for (int k = 0; k < HOLD; k++) tick();
    n_checks++; if (cpu_rst !== 1'b0) $display("FAIL full_run: got %b want 0", cpu_rst); else n_pass++;
    ld_valid = 1'b0;
    R = 1'b0;
    for (int j = 0; j < 3; j++) begin
      logic [7:0] a;
      a = (j == 0) ? 8'hFF : 8'(j - 1);
      addr = a;
      #1;
      n_checks++; if (mem_out !== a) $display("FAIL full_rd_%h: got %h want %h", a, mem_out, a); else n_pass++;
    end
    R = 1'b1;
    exp_out_data = 8'h00; exp_bus_err = 1'b0;
  endtask

  task automatic test_random();
    logic       r_s, w_s;
    logic [7:0] a_s, d_s;
    logic [7:0] exp_rd;
    for (int n = 0; n < 300; n++) begin
      r_s = 1'($urandom_range(0, 1));
      w_s = ($urandom_range(0, 3) != 0);
      a_s = ($urandom_range(0, 5) == 0) ? MMIO : 8'($urandom_range(0, 255));
      d_s = 8'($urandom_range(0, 255));
      R = r_s; W = w_s; addr = a_s; data_in = d_s;
      #1;
      exp_rd = r_s ? 8'h00 : model_ram[a_s];
      n_checks++; if (mem_out !== exp_rd) $display("FAIL rnd_rd_%0d: got %h want %h", n, mem_out, exp_rd); else n_pass++;
      exp_out_valid = 1'b0;
      if (!r_s && !w_s) begin
        exp_bus_err = 1'b1;
      end else if (!w_s) begin
        model_ram[a_s] = d_s;
        if (a_s == MMIO) begin
          exp_out_valid = 1'b1;
          exp_out_data  = d_s;
        end
      end
      tick();
      n_checks++;
      if (out_valid !== exp_out_valid || out_data !== exp_out_data || bus_err !== exp_bus_err)
        $display("FAIL rnd_port_%0d: got v=%b d=%h e=%b want v=%b d=%h e=%b",
                 n, out_valid, out_data, bus_err, exp_out_valid, exp_out_data, exp_bus_err);
      else n_pass++;
    end
    idle_inputs();
  endtask

  // Reset mid-load, reload from pointer 0, then reset in RUN and skip loading
  task automatic test_reset_midload();
    logic [7:0] want [4];
    apply_reset();
    for (int i = 0; i < 4; i++) begin
      ld_valid = 1'b1; ld_data = 8'hC0 + 8'(i);
      tick();
    end
    ld_data = 8'hC4;
    #2;
    rst = 1'b0;
    #1;
    n_checks++; if (ld_ready !== 1'b1 || cpu_rst !== 1'b1) $display("FAIL midload_rst: got %b/%b want 1/1", ld_ready, cpu_rst); else n_pass++;
    tick();
    rst = 1'b1;
    ld_valid = 1'b1; ld_data = 8'h77; ld_last = 1'b0;
    tick();
    ld_data = 8'h78; ld_last = 1'b1;
    tick();
    idle_inputs();
    for (int k = 0; k < HOLD; k++) begin
      n_checks++; if (cpu_rst !== 1'b1) $display("FAIL reload_hold_%0d: got %b want 1", k, cpu_rst); else n_pass++;
      tick();
    end
    n_checks++; if (cpu_rst !== 1'b0) $display("FAIL reload_run: got %b want 0", cpu_rst); else n_pass++;
    want[0] = 8'h77; want[1] = 8'h78; want[2] = 8'hC2; want[3] = 8'hC3;
    R = 1'b0;
    for (int i = 0; i < 4; i++) begin
      addr = 8'(i);
      #1;
      n_checks++; if (mem_out !== want[i]) $display("FAIL reload_rd_%0d: got %h want %h", i, mem_out, want[i]); else n_pass++;
    end
    R = 1'b1;
    // asynchronous reset from RUN, then skip the load
    #1;
    rst = 1'b0;
    #1;
    n_checks++; if (cpu_rst !== 1'b1 || ld_ready !== 1'b1) $display("FAIL run_async_rst: got %b/%b want 1/1", cpu_rst, ld_ready); else n_pass++;
    tick();
    rst = 1'b1;
    skip_load = 1'b1;
    tick();
    skip_load = 1'b0;
    for (int k = 0; k < HOLD; k++) begin
      n_checks++; if (cpu_rst !== 1'b1 || ld_ready !== 1'b0) $display("FAIL skip_hold_%0d: got %b/%b want 1/0", k, cpu_rst, ld_ready); else n_pass++;
      tick();
    end
    n_checks++; if (cpu_rst !== 1'b0) $display("FAIL skip_run: got %b want 0", cpu_rst); else n_pass++;
    R = 1'b0;
    for (int i = 0; i < 4; i++) begin
      addr = 8'(i);
      #1;
      n_checks++; if (mem_out !== want[i]) $display("FAIL skip_rd_%0d: got %h want %h", i, mem_out, want[i]); else n_pass++;
    end
    idle_inputs();
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    test_reset();
    test_load_short();
    test_run_rw();
    test_mmio();
    test_conflict();
    test_full_load();
    test_random();
    test_reset_midload();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_dmem_responder
`default_nettype wire
